// File: rtl/axi_rr_arbiter_pkg.sv
// Shared AXI encodings and arbiter state type for the NPC memory path.
// Imported by the arbiter, its picker and the future interconnect.
package npc_axi_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// AXI4 bundle with N lanes packed per field; N=1 describes the single slave port.
// The master modport drives requests, the slave modport drives responses.
interface axi_rr_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [N*ADDR_W-1:0] araddr;
  logic [N*8-1:0]      arlen;
  logic [N*3-1:0]      arsize;
  logic [N*2-1:0]      arburst;
  logic [N-1:0]        arvalid;
  logic [N-1:0]        arready;

  logic [N*DATA_W-1:0] rdata;
  logic [N*2-1:0]      rresp;
  logic [N-1:0]        rlast;
  logic [N-1:0]        rvalid;
  logic [N-1:0]        rready;

  logic [N*ADDR_W-1:0] awaddr;
  logic [N*8-1:0]      awlen;
  logic [N*3-1:0]      awsize;
  logic [N*2-1:0]      awburst;
  logic [N-1:0]        awvalid;
  logic [N-1:0]        awready;

  logic [N*DATA_W-1:0] wdata;
  logic [N*STRB_W-1:0] wstrb;
  logic [N-1:0]        wlast;
  logic [N-1:0]        wvalid;
  logic [N-1:0]        wready;

  logic [N*2-1:0]      bresp;
  logic [N-1:0]        bvalid;
  logic [N-1:0]        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/axi_rr_arbiter_rr_pick.sv
// Combinational N-way picker: round-robin after last_idx, or lowest index wins.
module rr_pick
  import npc_axi_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             rr_en,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [N-1:0] hi_s;
  logic [N-1:0] cand_s;
  logic         found_s;

  // Prefer requesters above last_idx; fall back to the full vector to wrap around.
  always_comb begin
    hi_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_s[i] = rr_en && (IDX_W'(i) > last_idx);
    end
    if ((req & hi_s) != '0) begin
      cand_s = req & hi_s;
    end else begin
      cand_s = req;
    end
  end

  // Lowest set candidate becomes the one-hot winner.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && cand_s[i]) begin
        found_s = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 burst arbiter; ownership is held from grant until the
// last R beat or the B response completes on the slave side.
module axi_rr_arbiter
  import npc_axi_pkg::*;
#(
  parameter int                     NUM_MASTERS = 2,
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 64,
  parameter bit                     RR_EN       = 1'b1,
  parameter logic [NUM_MASTERS-1:0] WR_EN_MASK  = {NUM_MASTERS{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_rr_arbiter_if.slave        m,
  axi_rr_arbiter_if.master       s,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   busy
);

  localparam int IDX_W  = idx_w(NUM_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  arb_state_e             state_r, state_nxt_s;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [IDX_W-1:0]       last_r;
  logic [NUM_MASTERS-1:0] req_s, win_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   any_s;

  assign req_s = m.arvalid | (m.awvalid & WR_EN_MASK);

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req      (req_s),
    .last_idx (last_r),
    .rr_en    (RR_EN),
    .win      (win_s),
    .win_idx  (win_idx_s),
    .any      (any_s)
  );

  // Next state: reads beat writes for a master raising both.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s = m.arvalid[win_idx_s] ? RD : WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (s.rvalid[0] && s.rready[0] && s.rlast[0]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD;
        end
      end
      WR: begin
        if (s.bvalid[0] && s.bready[0]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && any_s) begin
        grant_r <= win_s;
        last_r  <= win_idx_s;
      end else if (state_nxt_s == IDLE) begin
        grant_r <= '0;
      end else begin
        grant_r <= grant_r;
      end
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

  // Owner slice <-> slave mux; everything else stays quiet at zero.
  always_comb begin
    m.arready = '0;
    m.rdata   = '0;
    m.rresp   = '0;
    m.rlast   = '0;
    m.rvalid  = '0;
    m.awready = '0;
    m.wready  = '0;
    m.bresp   = '0;
    m.bvalid  = '0;
    s.araddr  = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arvalid = '0;
    s.rready  = '0;
    s.awaddr  = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.awvalid = '0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = '0;
    s.wvalid  = '0;
    s.bready  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_r[i] && (state_r == RD)) begin
        s.araddr                       = m.araddr[i*ADDR_W +: ADDR_W];
        s.arlen                        = m.arlen[i*LEN_W +: LEN_W];
        s.arsize                       = m.arsize[i*SIZE_W +: SIZE_W];
        s.arburst                      = m.arburst[i*BURST_W +: BURST_W];
        s.arvalid[0]                   = m.arvalid[i];
        m.arready[i]                   = s.arready[0];
        m.rdata[i*DATA_W +: DATA_W]    = s.rdata;
        m.rresp[i*RESP_W +: RESP_W]    = s.rresp;
        m.rlast[i]                     = s.rlast[0];
        m.rvalid[i]                    = s.rvalid[0];
        s.rready[0]                    = m.rready[i];
      end else if (grant_r[i] && (state_r == WR)) begin
        s.awaddr                       = m.awaddr[i*ADDR_W +: ADDR_W];
        s.awlen                        = m.awlen[i*LEN_W +: LEN_W];
        s.awsize                       = m.awsize[i*SIZE_W +: SIZE_W];
        s.awburst                      = m.awburst[i*BURST_W +: BURST_W];
        s.awvalid[0]                   = m.awvalid[i] & WR_EN_MASK[i];
        m.awready[i]                   = s.awready[0] & WR_EN_MASK[i];
        s.wdata                        = m.wdata[i*DATA_W +: DATA_W];
        s.wstrb                        = m.wstrb[i*STRB_W +: STRB_W];
        s.wlast[0]                     = m.wlast[i];
        s.wvalid[0]                    = m.wvalid[i] & WR_EN_MASK[i];
        m.wready[i]                    = s.wready[0] & WR_EN_MASK[i];
        m.bresp[i*RESP_W +: RESP_W]    = s.bresp;
        m.bvalid[i]                    = s.bvalid[0];
        s.bready[0]                    = m.bready[i];
      end else begin
        m.arready[i] = 1'b0;
      end
    end
  end

endmodule
